// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, state encoding and helpers for the SDF FFT controller
//
// Purpose : common definitions for fft_sdf_ctrl and fft_valid_chain.
// Contents: N / LOG2N / SAMPLE_W, per-stage delay table D_TAB (D_k = 16 >> k),
//           controller state enumeration, stage offset and bit-reverse helpers.
// Ports   : none (package).
package fft_pkg;

  localparam int N        = 32;
  localparam int LOG2N    = 5;
  localparam int SAMPLE_W = 19;

  // Delay-line depth of each stage; index k holds D_k.
  localparam logic [LOG2N-1:0][LOG2N-1:0] D_TAB = {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Cycle offset of stage k relative to stage 0: sum of the upstream delay
  // lines plus the pipeline registers behind each upstream butterfly.
  function automatic int stage_off(input int k, input int pipe);
    int off;
    off = 0;
    for (int i = 0; i < k; i++) begin
      off += int'(D_TAB[i]) + pipe;
    end
    return off;
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_valid_chain.sv
// rtl/fft_valid_chain.sv - enable-gated 1-bit valid shift register
//
// Purpose : tracks which datapath slots carry a real sample; advances only
//           when the datapath advances.
// Ports   : clk, rst (async, active-low), en (shift), din (new slot valid),
//           tail (valid bit of the slot leaving the datapath).
module fft_valid_chain #(
  parameter int LEN = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic tail
);

  logic [LEN-1:0] sr_q;
  logic [LEN-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d = {sr_q[LEN-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tail = sr_q[LEN-1];

endmodule

// File: rtl/fft_sdf_ctrl.sv
// rtl/fft_sdf_ctrl.sv - control sequencer for a 32-point radix-2 single-delay-feedback FFT
//
// Purpose : generates the shared advance enable, per-stage butterfly selects,
//           twiddle ROM addresses, output valid and output frequency index.
// Macro   : FFT_SDF_CTRL_BITREV_EN - when defined, out_idx is the bit-reversed
//           output count (natural frequency index); otherwise the raw count.
// Params  : PIPE - pipeline registers per butterfly stage (0..3).
// Ports   : clk, rst (async, active-low)
//           in_valid  - input sample present
//           flush     - single-cycle drain request
//           en        - advance enable for delay lines and stage registers
//           sel[4:0]  - per-stage select, 0 = fill/bypass, 1 = butterfly
//           tw_addr   - 5 x 4-bit twiddle addresses, field k for stage k
//           out_valid - output sample valid
//           out_idx   - frequency index of the output sample
//           busy      - controller in RUN or FLUSH
module fft_sdf_ctrl
  import fft_pkg::*;
#(
  parameter int PIPE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        flush,
  output logic        en,
  output logic [4:0]  sel,
  output logic [19:0] tw_addr,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic        busy
);

  localparam int         L    = 31 + 5 * PIPE;
  localparam logic [5:0] L_M1 = 6'(L - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  ocnt_q, ocnt_d;
  logic [5:0]  drain_q, drain_d;
  logic        en_c;
  logic        chain_in;
  logic        chain_tail;
  logic        drain_done;
  logic [4:0]  sel_raw;
  logic [19:0] tw_raw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ocnt_d     = ocnt_q;
    drain_d    = drain_q;
    en_c       = 1'b0;
    chain_in   = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // flush is ignored here; the first sample starts the frame.
        en_c     = in_valid;
        chain_in = in_valid;
        if (in_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A sample arriving with flush is still accepted this cycle.
        en_c     = in_valid;
        chain_in = in_valid;
        if (flush) begin
          state_d = ST_FLUSH;
          drain_d = '0;
        end
      end
      ST_FLUSH: begin
        // Free-run with bubbles until every in-flight sample has left.
        en_c = 1'b1;
        if (drain_q == L_M1) begin
          drain_done = 1'b1;
          state_d    = ST_IDLE;
          drain_d    = '0;
        end else begin
          drain_d = drain_q + 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (en_c) begin
      cnt_d = cnt_q + 5'd1;
    end
    if (out_valid) begin
      ocnt_d = ocnt_q + 5'd1;
    end
    if (drain_done) begin
      cnt_d  = '0;
      ocnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ocnt_q  <= ocnt_d;
      drain_q <= drain_d;
    end
  end

  // Gated by rst so an in_valid held high during reset cannot leak out.
  assign en   = en_c & rst;
  assign busy = (state_q != ST_IDLE);

  fft_valid_chain #(.LEN(L)) u_valid_chain (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (chain_in),
    .tail (chain_tail)
  );

  assign out_valid = en & chain_tail;

  // Stage k sees sample cnt - OFF_k; its select is the half-frame bit of that
  // local count, and the twiddle address is the remaining low bits scaled up
  // by k (stage k uses every 2^k-th twiddle). The 5-bit shift then truncation
  // to 4 bits is exactly c_k[3-k:0] << k, and is 0 for stage 4.
  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam logic [4:0] OFF_K = 5'(stage_off(k, PIPE));
    logic [4:0] c_k;
    logic [4:0] tw_sh;
    assign c_k                = cnt_q - OFF_K;
    assign tw_sh              = c_k << k;
    assign sel_raw[k]         = c_k[4-k];
    assign tw_raw[4*k +: 4]   = c_k[4-k] ? 4'h0 : tw_sh[3:0];
  end

  // Stage counters are meaningless before a frame starts, so hold 0 in IDLE.
  assign sel     = busy ? sel_raw : 5'd0;
  assign tw_addr = busy ? tw_raw  : 20'd0;

`ifdef FFT_SDF_CTRL_BITREV_EN
  assign out_idx = bitrev(ocnt_q);
`else
  assign out_idx = ocnt_q;
`endif

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// tb/tb_fft_sdf_ctrl.sv - scoreboard bench for fft_sdf_ctrl against a queue-based reference model
module tb_fft_sdf_ctrl;

  localparam int PIPE = 1;
  localparam int L    = 31 + 5 * PIPE;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        en;
  logic [4:0]  sel;
  logic [19:0] tw_addr;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic        busy;

  fft_sdf_ctrl #(.PIPE(PIPE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .flush     (flush),
    .en        (en),
    .sel       (sel),
    .tw_addr   (tw_addr),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int due;
    int idx;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: mode 0 idle, 1 running, 2 draining.
  int m_mode, m_cnt, m_acc, m_en, m_drain;
  int off[5];
  bit          exp_en;
  bit          exp_busy;
  logic [4:0]  exp_sel;
  logic [19:0] exp_tw;
  int          mon_en = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int idx_of(input int n);
    int r;
    r = n;
`ifdef FFT_SDF_CTRL_BITREV_EN
    r = 0;
    for (int i = 0; i < 5; i++) begin
      if (((n >> i) & 1) == 1) r |= (1 << (4 - i));
    end
`endif
    return r;
  endfunction

  // Evaluates this cycle's expected outputs from the inputs just driven, then
  // advances the model to the state after the coming clock edge.
  task automatic model_eval();
    exp_t e;
    int   c;
    int   s;
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_acc = 0; m_en = 0; m_drain = 0;
      exp_q.delete();
      exp_en = 0; exp_busy = 0; exp_sel = '0; exp_tw = '0;
      return;
    end
    exp_en   = (m_mode == 2) ? 1'b1 : in_valid;
    exp_busy = (m_mode != 0);
    exp_sel  = '0;
    exp_tw   = '0;
    if (exp_busy) begin
      for (int k = 0; k < 5; k++) begin
        c = ((m_cnt - off[k]) % 32 + 32) % 32;
        s = (c >> (4 - k)) & 1;
        exp_sel[k] = s[0];
        if (s == 0) exp_tw[4*k +: 4] = 4'((c << k) & 15);
      end
    end
    if (exp_en && m_mode != 2) begin
      e.due = m_en + L;
      e.idx = idx_of(m_acc);
      exp_q.push_back(e);
      m_acc = (m_acc + 1) % 32;
    end
    if (exp_en) begin
      m_cnt = (m_cnt + 1) % 32;
      m_en++;
    end
    case (m_mode)
      0: if (in_valid) m_mode = 1;
      1: if (flush) begin m_mode = 2; m_drain = 0; end
      default: begin
        m_drain++;
        if (m_drain == L) begin
          m_mode = 0; m_cnt = 0; m_acc = 0; m_drain = 0;
        end
      end
    endcase
  endtask

  task automatic step(input bit iv, input bit fl);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = iv;
    flush    = fl;
    model_eval();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    model_eval();
  endtask

  task automatic drain(input string name);
    repeat (L + 3) step(1'b0, 1'b0);
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    bit   due;
    exp_t e;
    if (!rst) begin
      mon_en = 0;
      check("rst_en", en, 0);
      check("rst_sel", sel, 0);
      check("rst_tw_addr", tw_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_busy", busy, 0);
    end else begin
      check("en", en, exp_en);
      check("sel", sel, exp_sel);
      check("tw_addr", tw_addr, exp_tw);
      check("busy", busy, exp_busy);
      due = exp_en && (exp_q.size() > 0) && (exp_q[0].due == mon_en);
      check("out_valid", out_valid, due);
      if (out_valid && due) begin
        e = exp_q.pop_front();
        check("out_idx", out_idx, e.idx);
      end
      if (exp_en) mon_en++;
    end
  end

  initial begin : driver
    int n;
    bit iv;
    off[0] = 0;
    for (int k = 1; k < 5; k++) off[k] = off[k-1] + (16 >> (k - 1)) + PIPE;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    model_eval();
    do_reset();
    do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Two back-to-back frames, then flush and drain.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    drain("drain_two_frames");

    // Alternating gaps across one frame.
    for (int i = 0; i < 64; i++) step(i % 2 == 0, 1'b0);
    step(1'b0, 1'b1);
    drain("drain_toggle");

    // Random gaps, flush with the last sample, noise during the drain.
    n = 0;
    while (n < 32) begin
      iv = 1'($urandom_range(0, 1));
      step(iv, iv && (n == 31));
      if (iv) n++;
    end
    for (int i = 0; i < L; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain("drain_flush_with_sample");

    // Reset mid-frame, then a clean frame.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
